// File: rtl/inv_selftest_pkg.sv
// Shared definitions for the inverter self-test controller: FSM states,
// LFSR seed/taps and the LFSR next-state function.
package inv_selftest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // x^8+x^6+x^5+x^4+1 with the register shifting toward bit 0
  localparam logic [7:0] LFSR_TAPS = 8'h1D;

  // Bit of the LFSR that is presented to the inverter
  localparam logic [7:0] STIM_MASK = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {^(q & LFSR_TAPS), q[7:1]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR: reset and load both restore the shared seed,
// step advances one position.
module lfsr8
  import inv_selftest_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/inv_selftest_ctrl.sv
// Built-in self-test controller for a single inverter datapath: drives
// pseudo-random bits, waits LAT cycles, checks the inverted response.
module inv_selftest_ctrl
  import inv_selftest_pkg::*;
#(
  parameter int N_VECTORS = 16,
  parameter int LAT       = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_x,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]       LAST_VEC = 8'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t     state;
  logic [7:0] vec_cnt;
  logic [3:0] wait_cnt;
  logic [7:0] lfsr_q;
  logic       lfsr_load;
  logic       lfsr_step;

  assign lfsr_load = (state == IDLE) && start;
  assign lfsr_step = (state == CHECK);

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dut_x     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_cnt   <= 8'd0;
      wait_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            busy      <= 1'b1;
            err_count <= '0;
            pass      <= 1'b0;
            vec_cnt   <= 8'd0;
          end
        end
        DRIVE: begin
          dut_x    <= ^(lfsr_q & STIM_MASK);
          wait_cnt <= 4'(LAT);
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          // Saturate rather than wrap so a long faulty run never reads as clean
          if ((dut_y != ~dut_x) && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
          end
          if (vec_cnt == LAST_VEC) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            vec_cnt <= vec_cnt + 8'd1;
            state   <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          pass  <= (err_count == '0);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_selftest_ctrl.sv
// Self-checking bench for inv_selftest_ctrl: randomized fault patterns
// compared against a behavioural model of the run.
module tb_inv_selftest_ctrl;

  localparam int N    = 16;
  localparam int LAT  = 1;
  localparam int NB   = 5;
  localparam int LATB = 3;
  localparam int RUN_EDGES = 1 + N * (LAT + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic flip = 1'b0;

  logic x_a, y_a, busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic x_c, y_c, busy_c, done_c, pass_c;
  logic [2:0] err_c;
  logic x_b, y_b, busy_b, done_b, pass_b;
  logic [7:0] err_b;

  assign y_a = ~x_a ^ flip;
  assign y_c = ~x_c ^ flip;
  assign y_b = ~x_b;

  always #5 clk = ~clk;

  inv_selftest_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dut_x(x_a), .dut_y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a)
  );

  inv_selftest_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .dut_x(x_c), .dut_y(y_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c)
  );

  inv_selftest_ctrl #(.N_VECTORS(NB), .LAT(LATB)) dut_slow (
    .clk(clk), .rst(rst), .start(start), .dut_x(x_b), .dut_y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b)
  );

  int checks = 0;
  int errors = 0;

  int edge_cnt;
  int done_a_edge, done_b_edge, done_c_edge, done_a_cycles;
  int unstable;
  logic obs_x[N];
  logic [7:0] obs_err[N];
  logic [2:0] obs_err_c[N];
  logic exp_x[N];

  // Reference stimulus: bit 0 of a right-shifting x^8+x^6+x^5+x^4+1 LFSR from A5
  function automatic void build_model();
    logic [7:0] s;
    logic fb;
    s = 8'hA5;
    for (int k = 0; k < N; k++) begin
      exp_x[k] = s[0];
      fb = s[0] ^ s[2] ^ s[3] ^ s[4];
      s = {fb, s[7:1]};
    end
  endfunction

  function automatic int sat(input int v, input int width);
    int top;
    top = (1 << width) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
    if (done_a) begin
      done_a_cycles++;
      if (done_a_edge < 0) done_a_edge = edge_cnt;
    end
    if (done_b && done_b_edge < 0) done_b_edge = edge_cnt;
    if (done_c && done_c_edge < 0) done_c_edge = edge_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    flip = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One full run: flips[k] corrupts the response for vector k; optional stray start
  task automatic applyStimulus(input logic [N-1:0] flips, input int glitch_vec);
    @(negedge clk);
    start = 1'b1;
    flip = flips[0];
    edge_cnt = 0;
    done_a_edge = -1;
    done_b_edge = -1;
    done_c_edge = -1;
    done_a_cycles = 0;
    unstable = 0;
    tick();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      flip = flips[k];
      if (k == glitch_vec) start = 1'b1;
      tick();
      start = 1'b0;
      obs_x[k] = x_a;
      for (int w = 0; w <= LAT; w++) begin
        tick();
        if (x_a !== obs_x[k]) unstable++;
      end
      obs_err[k] = err_a;
      obs_err_c[k] = err_c;
    end
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy_a);
    end
    checks++;
    if (done_a !== 1'b0 || pass_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done_pass: got done=%b pass=%b expected 0 0", done_a, pass_a);
    end
    checks++;
    if (err_a !== 8'd0 || err_c !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_err: got %0d/%0d expected 0/0", err_a, err_c);
    end
    checks++;
    if (x_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut_x: got %b expected 0", x_a);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || x_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got busy=%b dut_x=%b expected 0 0", busy_a, x_a);
    end
  endtask

  task automatic test_ideal();
    int bad_x;
    do_reset();
    applyStimulus('0, -1);
    checks++;
    if (done_a_edge != RUN_EDGES || done_a_cycles != 1) begin
      errors++;
      $display("[TB] FAIL ideal_done_timing: got edge %0d width %0d expected edge %0d width 1",
               done_a_edge, done_a_cycles, RUN_EDGES);
    end
    checks++;
    if (pass_a !== 1'b1 || err_a !== 8'd0) begin
      errors++;
      $display("[TB] FAIL ideal_verdict: got pass=%b err=%0d expected 1 0", pass_a, err_a);
    end
    checks++;
    if (obs_x[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_dut_x: got %b expected 1", obs_x[0]);
    end
    bad_x = 0;
    for (int k = 0; k < N; k++) if (obs_x[k] !== exp_x[k]) bad_x++;
    checks++;
    if (bad_x != 0) begin
      errors++;
      $display("[TB] FAIL lfsr_sequence: got %0d wrong vectors expected 0", bad_x);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("[TB] FAIL dut_x_stable: got %0d changes expected 0", unstable);
    end
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ideal_end_idle: got busy=%b done=%b expected 0 0", busy_a, done_a);
    end
    checks++;
    if (done_b_edge != 1 + NB * (LATB + 2) || pass_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL slow_cfg_run: got edge %0d pass=%b expected %0d 1",
               done_b_edge, pass_b, 1 + NB * (LATB + 2));
    end
  endtask

  // Shared checker body for any fault pattern, recomputed from the flip mask
  task automatic test_fault_pattern(input logic [N-1:0] flips, input string name);
    int running, bad_mid;
    do_reset();
    applyStimulus(flips, -1);
    running = 0;
    bad_mid = 0;
    for (int k = 0; k < N; k++) begin
      if (flips[k]) running++;
      if (obs_err[k] !== 8'(sat(running, 8)) || obs_err_c[k] !== 3'(sat(running, 3))) bad_mid++;
    end
    checks++;
    if (bad_mid != 0) begin
      errors++;
      $display("[TB] FAIL %s_running_count: got %0d wrong samples expected 0", name, bad_mid);
    end
    checks++;
    if (err_a !== 8'(sat(running, 8)) || pass_a !== (running == 0)) begin
      errors++;
      $display("[TB] FAIL %s_final: got err=%0d pass=%b expected err=%0d pass=%b",
               name, err_a, pass_a, sat(running, 8), (running == 0));
    end
    checks++;
    if (err_c !== 3'(sat(running, 3)) || pass_c !== (running == 0)) begin
      errors++;
      $display("[TB] FAIL %s_sat_final: got err=%0d pass=%b expected err=%0d pass=%b",
               name, err_c, pass_c, sat(running, 3), (running == 0));
    end
    checks++;
    if (done_a_edge != RUN_EDGES) begin
      errors++;
      $display("[TB] FAIL %s_done_timing: got %0d expected %0d", name, done_a_edge, RUN_EDGES);
    end
  endtask

  task automatic test_stuck_fault();
    test_fault_pattern('1, "stuck");
  endtask

  task automatic test_single_error();
    test_fault_pattern(16'h0020, "vec5");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      test_fault_pattern(N'($urandom), "random");
    end
  endtask

  task automatic test_ignored_start();
    do_reset();
    applyStimulus('0, 3);
    checks++;
    if (done_a_edge != RUN_EDGES || done_a_cycles != 1 || pass_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_start: got edge %0d width %0d pass=%b expected %0d 1 1",
               done_a_edge, done_a_cycles, pass_a, RUN_EDGES);
    end
  endtask

  task automatic test_back_to_back();
    int done_edges[$];
    do_reset();
    @(negedge clk);
    start = 1'b1;
    edge_cnt = 0;
    for (int e = 0; e < 160; e++) begin
      tick();
      if (done_a) done_edges.push_back(edge_cnt);
    end
    start = 1'b0;
    checks++;
    if (done_edges.size() != 3) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d done pulses expected 3", done_edges.size());
    end else begin
      checks++;
      if (done_edges[0] != RUN_EDGES || done_edges[1] != RUN_EDGES + 50 ||
          done_edges[2] != RUN_EDGES + 100) begin
        errors++;
        $display("[TB] FAIL b2b_spacing: got %0d %0d %0d expected %0d %0d %0d",
                 done_edges[0], done_edges[1], done_edges[2],
                 RUN_EDGES, RUN_EDGES + 50, RUN_EDGES + 100);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    @(negedge clk);
    start = 1'b1;
    flip = 1'b1;
    edge_cnt = 0;
    tick();
    start = 1'b0;
    repeat (22) tick();
    checks++;
    if (err_a !== 8'd7 || busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_progress: got err=%0d busy=%b expected 7 1", err_a, busy_a);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got busy=%b done=%b err=%0d expected 0 0 0",
               busy_a, done_a, err_a);
    end
    rst = 1'b0;
    flip = 1'b0;
    applyStimulus('0, -1);
    checks++;
    if (done_a_edge != RUN_EDGES || pass_a !== 1'b1 || err_a !== 8'd0) begin
      errors++;
      $display("[TB] FAIL after_reset_run: got edge %0d pass=%b err=%0d expected %0d 1 0",
               done_a_edge, pass_a, err_a, RUN_EDGES);
    end
  endtask

  task automatic test_pass_hold();
    do_reset();
    applyStimulus('0, -1);
    repeat (5) tick();
    checks++;
    if (pass_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_hold: got pass=%b busy=%b expected 1 0", pass_a, busy_a);
    end
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (pass_a !== 1'b0 || busy_a !== 1'b1 || err_a !== 8'd0) begin
      errors++;
      $display("[TB] FAIL pass_clear_on_start: got pass=%b busy=%b err=%0d expected 0 1 0",
               pass_a, busy_a, err_a);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_ideal();
    test_stuck_fault();
    test_single_error();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_midrun();
    test_pass_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_selftest_ctrl.md
INV_SELFTEST_CTRL -- requirements
Module: inv_selftest_ctrl

Interface
REQ-001 The block SHALL have parameter N_VECTORS, default 16; the number of test vectors per run (range 1..255).
REQ-002 The block SHALL have parameter LAT, default 1; the cycles waited between driving dut_x and sampling dut_y (range 1..15).
REQ-003 The block SHALL have parameter CNT_W, default 8; the width of err_count.
REQ-004 The block SHALL have port clk, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit; a run request, sampled only in IDLE.
REQ-007 The block SHALL have port dut_x, output, 1 bit, registered; the stimulus to the inverter datapath input.
REQ-008 The block SHALL have port dut_y, input, 1 bit; the inverter datapath output.
REQ-009 The block SHALL have port busy, output, 1 bit; high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit; a one-cycle pulse at the end of a run.
REQ-011 The block SHALL have port pass, output, 1 bit; the run verdict, held until the next accepted start.
REQ-012 The block SHALL have port err_count, output, CNT_W bits; the count of mismatches in the current or last run.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-014 In IDLE with start=1, the block SHALL go to DRIVE, clear err_count, clear pass, clear vec_cnt and load the LFSR with 8'hA5.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE, and all outputs SHALL hold their values.
REQ-016 In DRIVE, the block SHALL register dut_x <= lfsr[0], load wait_cnt with LAT, and go to WAIT.
REQ-017 In WAIT, the block SHALL decrement wait_cnt and go to CHECK when wait_cnt reaches 1, so it stays in WAIT for exactly LAT cycles.
REQ-018 In CHECK, if dut_y != ~dut_x, err_count SHALL increment, saturating at 2^CNT_W-1 with no wrap.
REQ-019 In CHECK, the LFSR SHALL advance one step (x^8+x^6+x^5+x^4+1, Fibonacci, shift toward bit 0).
REQ-020 In CHECK, if vec_cnt == N_VECTORS-1 the block SHALL go to DONE; otherwise vec_cnt SHALL increment and the block SHALL go to DRIVE.
REQ-021 In DONE, the block SHALL assert done=1 for exactly one cycle, register pass <= (err_count == 0) (using the final count), and return to IDLE.
REQ-022 Each vector SHALL take exactly LAT+2 cycles.
REQ-023 done SHALL be high in the cycle after 1 + N_VECTORS*(LAT+2) rising edges, counted from the edge that samples start.
REQ-024 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 start held high through DONE SHALL begin a new run on the first IDLE cycle.
REQ-026 dut_x SHALL change only on DRIVE-state edges and SHALL be stable throughout WAIT and CHECK.
REQ-027 err_count SHALL be readable at any time, and its value during a run SHALL be the count so far.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL go to IDLE regardless of state, including mid-run, and any partial run SHALL be discarded.
REQ-029 The reset values SHALL be: dut_x=0, busy=0, done=0, pass=0, err_count=0, vec_cnt=0, wait_cnt=0, LFSR=8'hA5.
REQ-030 rst SHALL take priority over start in the same cycle.

Structure
REQ-031 The state encoding, the LFSR seed 8'hA5 and the tap mask SHALL live in the shared package inv_selftest_pkg.
REQ-032 The LFSR SHALL be a separate sub-module lfsr8 with inputs clk, rst, load and step, and output q[7:0].
REQ-033 The FSM, the counters and the compare logic SHALL stay in inv_selftest_ctrl.

Verification
REQ-034 With an ideal inverter (dut_y = ~dut_x), defaults, and a one-cycle start pulse, done SHALL be high after 49 edges, with pass=1, err_count=0, and first dut_x=1.
REQ-035 With a non-inverting fault (dut_y = dut_x) and defaults, the run SHALL end with err_count=16 and pass=0.
REQ-036 With dut_y forced wrong only during the vector-5 CHECK cycle, the run SHALL end with err_count=1 and pass=0.
REQ-037 With CNT_W=3 and a non-inverting fault, the run SHALL end with err_count=7 (saturated) and pass=0.
REQ-038 A start pulse at vector 3 SHALL be ignored with no timing change; start held high SHALL cause back-to-back runs with done every 50 cycles.
REQ-039 With rst asserted for one cycle during vector 7, busy, done and err_count SHALL be 0 on the next edge; a following start SHALL give a full 49-edge run with pass=1.
